i2c_cmd_arbiter: RTL and testbench
==================================

I2C_CMD_ARBITER -- requirements
Module: i2c_cmd_arbiter

Interface
REQ-001 Parameter MAX_RETRY, default 3: NACK retries per command before error.
REQ-002 Parameter TIMEOUT_CYC, default 20000: iCLK cycles allowed between GO rise and END.
REQ-003 iCLK  in  1  system clock; all ports synchronous to it.
REQ-004 iRST_N  in  1  asynchronous, active-low reset.
REQ-005 iREQ  in  3  per-requester command request, held until matching oDONE bit.
REQ-006 iCMD0, iCMD1, iCMD2  in  24 each  {slave_addr, sub_addr, data}, stable while iREQ bit high.
REQ-007 oDONE  out  3  one-cycle completion pulse per requester.
REQ-008 oERR  out  3  valid with oDONE bit; 1 = retries exhausted or timeout.
REQ-009 oI2C_DATA  out  24  word to I2C controller.
REQ-010 oI2C_GO  out  1  transfer start to I2C controller.
REQ-011 iI2C_END  in  1  controller transfer-finished flag.
REQ-012 iI2C_ACK  in  1  controller ACK flag; 0 = acknowledged, 1 = NACK.
REQ-013 oBUSY  out  1  high in any state except IDLE.
REQ-014 oGNT  out  2  index of requester currently owning the bus, valid while oBUSY.

Function
REQ-015 FSM states IDLE, LAUNCH, WAIT_END, RELEASE, RESP.
REQ-016 IDLE: if any iREQ bit set, pick winner round-robin starting after last-served index, latch its iCMD into oI2C_DATA, set oGNT, go LAUNCH next cycle.
REQ-017 Round-robin pointer after reset = 2, so requester 0 wins first; pointer updates only in RESP.
REQ-018 LAUNCH: assert oI2C_GO only when iI2C_END is 0, else wait; on assert go WAIT_END, clear timeout counter.
REQ-019 WAIT_END: hold oI2C_GO=1 and oI2C_DATA constant; on iI2C_END=1 sample iI2C_ACK, drop oI2C_GO, go RELEASE.
REQ-020 RELEASE: oI2C_GO=0 at least one cycle and until iI2C_END=0; then ACK=0 -> RESP ok; ACK=1 and retry count < MAX_RETRY -> increment count, LAUNCH; else RESP error.
REQ-021 RESP: pulse oDONE[oGNT] for exactly one cycle with oERR[oGNT]; clear retry count; go IDLE.
REQ-022 Requesters not granted are never pulsed; oDONE is one-hot or zero.
REQ-023 iREQ bit dropping mid-transfer does not abort; the transfer completes and oDONE still pulses.
REQ-024 Simultaneous requests: exactly one grant per arbitration; no requester waits more than two other transfers.
REQ-025 Retry count width clog2(MAX_RETRY+1); MAX_RETRY=0 means no retry.
REQ-026 Command latched once at grant; iCMD changes afterward are ignored, including across retries.

Reset
REQ-027 iRST_N low asynchronously forces IDLE, oI2C_GO=0, oI2C_DATA=0, oDONE=0, oERR=0, oBUSY=0, oGNT=0, retry count 0, timeout counter 0, pointer 2.
REQ-028 Reset mid-transfer drops oI2C_GO immediately; no oDONE for the interrupted command.

Configuration
REQ-029 Macro I2C_ARB_TIMEOUT_EN defined: WAIT_END counts cycles; reaching TIMEOUT_CYC drops oI2C_GO, goes RELEASE treated as NACK, no retry, oERR=1.
REQ-030 Macro I2C_ARB_TIMEOUT_EN undefined: no counter synthesized; WAIT_END waits on iI2C_END indefinitely.

Verification
REQ-031 iREQ=001, iCMD0=34_001A, controller ACK=0 after 10 cycles -> oI2C_DATA=34001A, one GO, oDONE=001, oERR=000.
REQ-032 iREQ=111 held, all ACK -> service order 0,1,2, three oDONE pulses, one GO per command.
REQ-033 iREQ=010, controller NACKs every attempt, MAX_RETRY=3 -> 4 GO pulses, then oDONE=010, oERR=010.
REQ-034 Macro defined, TIMEOUT_CYC=50, END never asserts -> GO drops 50 cycles after rise, oDONE/oERR pulse for owner.
REQ-035 iRST_N low during WAIT_END -> oI2C_GO=0 same cycle, oBUSY=0, no oDONE; after release, a new iREQ=100 is served normally.
REQ-036 iCMD0 changed after grant while NACK retries -> every retry sends original latched word.

Source files
------------

// File: rtl/i2c_cmd_arbiter_if.sv
// I2C controller side of the command arbiter.
// master = arbiter, slave = I2C controller.
interface i2c_cmd_arbiter_if;
  logic [23:0] oI2C_DATA;
  logic        oI2C_GO;
  logic        iI2C_END;
  logic        iI2C_ACK;

  modport master (
    output oI2C_DATA,
    output oI2C_GO,
    input  iI2C_END,
    input  iI2C_ACK
  );

  modport slave (
    input  oI2C_DATA,
    input  oI2C_GO,
    output iI2C_END,
    output iI2C_ACK
  );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter for three I2C command requesters with NACK retry.
// Optional WAIT_END watchdog enabled by macro I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter #(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [2:0]  iREQ,
  input  logic [23:0] iCMD0,
  input  logic [23:0] iCMD1,
  input  logic [23:0] iCMD2,
  output logic [2:0]  oDONE,
  output logic [2:0]  oERR,
  output logic        oBUSY,
  output logic [1:0]  oGNT,
  i2c_cmd_arbiter_if.master bus
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  if (MAX_RETRY < 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("i2c_cmd_arbiter: bad parameters");
  end

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_END,
    RELEASE,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [23:0]   data_q, data_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          nack_q, nack_d;
  logic          err_q, err_d;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          tmo_q, tmo_d;
`endif

  logic [1:0]  c1, c2, win;
  logic [23:0] win_cmd;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pick the first requester after the last-served one.
  always_comb begin
    c1 = nxt(ptr_q);
    c2 = nxt(c1);
    win = ptr_q;
    if (iREQ[c1])      win = c1;
    else if (iREQ[c2]) win = c2;
    win_cmd = iCMD0;
    unique case (win)
      2'd1:    win_cmd = iCMD1;
      2'd2:    win_cmd = iCMD2;
      default: win_cmd = iCMD0;
    endcase
  end

  // Next-state logic of the transfer FSM.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    retry_d = retry_q;
    nack_d  = nack_q;
    err_d   = err_q;
`ifdef I2C_ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|iREQ) begin
          gnt_d   = win;
          data_d  = win_cmd;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (!bus.iI2C_END) begin
          state_d = WAIT_END;
`ifdef I2C_ARB_TIMEOUT_EN
          tcnt_d  = '0;
          tmo_d   = 1'b0;
`endif
        end
      end
      WAIT_END: begin
        if (bus.iI2C_END) begin
          nack_d  = bus.iI2C_ACK;
          state_d = RELEASE;
        end
`ifdef I2C_ARB_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          nack_d  = 1'b1;
          tmo_d   = 1'b1;
          state_d = RELEASE;
        end else begin
          tcnt_d  = tcnt_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (!bus.iI2C_END) begin
          if (!nack_q) begin
            err_d   = 1'b0;
            state_d = RESP;
          end else if (retry_q < RW'(MAX_RETRY)
`ifdef I2C_ARB_TIMEOUT_EN
                       && !tmo_q
`endif
                      ) begin
            retry_d = retry_q + 1'b1;
            state_d = LAUNCH;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        retry_d = '0;
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      gnt_q   <= 2'd0;
      ptr_q   <= 2'd2;
      data_q  <= '0;
      retry_q <= '0;
      nack_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      retry_q <= retry_d;
      nack_q  <= nack_d;
      err_q   <= err_d;
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  // Watchdog counter for the WAIT_END state.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end
`endif

  assign bus.oI2C_GO   = (state_q == WAIT_END);
  assign bus.oI2C_DATA = data_q;
  assign oBUSY = (state_q != IDLE);
  assign oGNT  = gnt_q;
  assign oDONE = (state_q == RESP) ? (3'b001 << gnt_q) : 3'b000;
  assign oERR  = (state_q == RESP && err_q) ? (3'b001 << gnt_q) : 3'b000;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter.
// Vector table plus reset and watchdog sequences.
module tb_i2c_cmd_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [2:0]  iREQ = '0;
  logic [23:0] iCMD0 = '0, iCMD1 = '0, iCMD2 = '0;
  logic [2:0]  oDONE, oERR;
  logic        oBUSY;
  logic [1:0]  oGNT;

  i2c_cmd_arbiter_if bus();

  i2c_cmd_arbiter #(
    .MAX_RETRY(3),
    .TIMEOUT_CYC(50)
  ) dut (
    .iCLK(iCLK),
    .iRST_N(iRST_N),
    .iREQ(iREQ),
    .iCMD0(iCMD0),
    .iCMD1(iCMD1),
    .iCMD2(iCMD2),
    .oDONE(oDONE),
    .oERR(oERR),
    .oBUSY(oBUSY),
    .oGNT(oGNT),
    .bus(bus)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [2:0]  req;
    logic [23:0] c0, c1, c2;
    int          dly;
    int          nacks;
    logic        mut;
    int          ndone;
    int          ngo;
    logic [5:0]  ord;
    logic [2:0]  err;
  } vec_t;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic do_reset();
    iRST_N = 1'b0;
    iREQ = '0;
    bus.iI2C_END = 1'b0;
    bus.iI2C_ACK = 1'b0;
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
  endtask

  task automatic run_vec(input vec_t v, input logic rst, input string tag);
    int dones = 0, gos = 0, cyc = 0, cnt = 0, nl;
    logic [5:0]  ord = '0;
    logic [2:0]  errs = '0;
    logic        gp = 1'b0;
    logic [1:0]  own, idx;
    logic [23:0] orig [3];
    if (rst) do_reset();
    iCMD0 = v.c0;
    iCMD1 = v.c1;
    iCMD2 = v.c2;
    orig[0] = v.c0;
    orig[1] = v.c1;
    orig[2] = v.c2;
    nl = v.nacks;
    iREQ = v.req;
    while (dones < v.ndone && cyc < 2000) begin
      @(negedge iCLK);
      cyc++;
      if (bus.oI2C_GO && !gp) begin
        gos++;
        cnt = 0;
        own = v.ord[2*dones +: 2];
        chk({tag, " word"}, {8'h0, bus.oI2C_DATA}, {8'h0, orig[own]});
        if (v.mut) iCMD0 = ~iCMD0;
      end
      if (bus.oI2C_GO && !bus.iI2C_END) begin
        cnt++;
        if (cnt == v.dly) begin
          bus.iI2C_END = 1'b1;
          bus.iI2C_ACK = (nl != 0);
          if (nl > 0) nl--;
        end
      end else if (!bus.oI2C_GO && bus.iI2C_END) begin
        bus.iI2C_END = 1'b0;
      end
      if (oDONE != 3'b000) begin
        own = v.ord[2*dones +: 2];
        chk({tag, " done"}, {29'h0, oDONE}, 32'h1 << own);
        chk({tag, " err_w"}, {29'h0, oERR & ~oDONE}, 32'h0);
        idx = oDONE[0] ? 2'd0 : (oDONE[1] ? 2'd1 : 2'd2);
        ord[2*dones +: 2] = idx;
        errs |= oERR;
        iREQ[idx] = 1'b0;
        dones++;
      end
      gp = bus.oI2C_GO;
    end
    chk({tag, " ndone"}, dones, v.ndone);
    chk({tag, " ngo"}, gos, v.ngo);
    chk({tag, " order"}, {26'h0, ord}, {26'h0, v.ord});
    chk({tag, " errs"}, {29'h0, errs}, {29'h0, v.err});
    @(negedge iCLK);
    chk({tag, " idle"}, {31'h0, oBUSY}, 32'h0);
  endtask

  vec_t vt [8];

  initial begin
    int n, hi;
    vec_t v;

    vt[0] = '{3'b001, 24'h34001A, 24'h0, 24'h0, 10, 0, 1'b0, 1, 1,
              {2'd0, 2'd0, 2'd0}, 3'b000};
    vt[1] = '{3'b111, 24'h111111, 24'h222222, 24'h333333, 3, 0, 1'b0, 3, 3,
              {2'd2, 2'd1, 2'd0}, 3'b000};
    vt[2] = '{3'b010, 24'h0, 24'hABCDEF, 24'h0, 4, -1, 1'b0, 1, 4,
              {2'd0, 2'd0, 2'd1}, 3'b010};
    vt[3] = '{3'b001, 24'h5A5A5A, 24'h0, 24'h0, 2, 2, 1'b1, 1, 3,
              {2'd0, 2'd0, 2'd0}, 3'b000};
    vt[4] = '{3'b101, 24'h0A0B0C, 24'h0, 24'hC0B0A0, 5, 0, 1'b0, 2, 2,
              {2'd0, 2'd2, 2'd0}, 3'b000};
    vt[5] = '{3'b110, 24'h0, 24'h123456, 24'h654321, 2, 0, 1'b0, 2, 2,
              {2'd0, 2'd2, 2'd1}, 3'b000};
    vt[6] = '{3'b011, 24'hFEDCBA, 24'h13579B, 24'h0, 3, 4, 1'b0, 2, 5,
              {2'd0, 2'd1, 2'd0}, 3'b001};
    vt[7] = '{3'b100, 24'h0, 24'h0, 24'h777777, 1, 0, 1'b0, 1, 1,
              {2'd0, 2'd0, 2'd2}, 3'b000};

    bus.iI2C_END = 1'b0;
    bus.iI2C_ACK = 1'b0;
    #1;
    chk("rst busy", {31'h0, oBUSY}, 32'h0);
    chk("rst go", {31'h0, bus.oI2C_GO}, 32'h0);
    chk("rst data", {8'h0, bus.oI2C_DATA}, 32'h0);
    chk("rst done", {29'h0, oDONE}, 32'h0);
    chk("rst err", {29'h0, oERR}, 32'h0);
    chk("rst gnt", {30'h0, oGNT}, 32'h0);

    for (int i = 0; i < 8; i++)
      run_vec(vt[i], 1'b1, $sformatf("v%0d", i));

    // reset while WAIT_END
    do_reset();
    iCMD2 = 24'h999999;
    iREQ = 3'b100;
    n = 0;
    while (!bus.oI2C_GO && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    chk("mid go up", {31'h0, bus.oI2C_GO}, 32'h1);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    chk("mid go", {31'h0, bus.oI2C_GO}, 32'h0);
    chk("mid busy", {31'h0, oBUSY}, 32'h0);
    chk("mid done", {29'h0, oDONE}, 32'h0);
    iREQ = 3'b000;
    @(negedge iCLK);
    chk("mid done2", {29'h0, oDONE}, 32'h0);
    iRST_N = 1'b1;
    @(negedge iCLK);
    run_vec(vt[7], 1'b0, "post");

`ifdef I2C_ARB_TIMEOUT_EN
    do_reset();
    iCMD0 = 24'h0BAD00;
    iREQ = 3'b001;
    n = 0;
    while (!bus.oI2C_GO && n < 100) begin
      @(negedge iCLK);
      n++;
    end
    hi = 0;
    while (bus.oI2C_GO && hi < 200) begin
      @(negedge iCLK);
      hi++;
    end
    chk("tmo go len", hi, 50);
    n = 0;
    while (oDONE == 3'b000 && n < 20) begin
      @(negedge iCLK);
      n++;
    end
    chk("tmo done", {29'h0, oDONE}, 32'h1);
    chk("tmo err", {29'h0, oERR}, 32'h1);
    iREQ = 3'b000;
    @(negedge iCLK);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
